// File: rtl/rsc_frame_encoder.sv
// rsc_frame_encoder: rate-1/2 recursive systematic convolutional encoder
// (feedback 7, feedforward 5), trellis-terminated 7-step frames mapped to
// signed 4-bit LLR nibbles and issued to the SISO one frame per credit.
module rsc_frame_encoder #(
   parameter int LLR_MAG = 7
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        in_valid_i,
   input  logic        in_bit_i,
   output logic        in_ready_o,
   input  logic        siso_done_i,
   output logic        read_en_o,
   output logic [27:0] sys_o,
   output logic [27:0] enc_o,
   output logic [15:0] frame_cnt_o,
   output logic        proto_err_o
);

   typedef enum logic [1:0] {S_LOAD, S_TAIL, S_WAIT, S_ISSUE} state_t;

   localparam logic signed [3:0] LLR_POS = 4'(LLR_MAG);
   localparam logic signed [3:0] LLR_NEG = -LLR_POS;

   // Bit 1 maps to +LLR_MAG, bit 0 to -LLR_MAG.
   function automatic logic signed [3:0] llr_map(input logic b);
      return b ? LLR_POS : LLR_NEG;
   endfunction

   state_t            state, state_nxt;
   logic [2:0]        step;
   logic              s1, s2;
   logic              credit;
   logic signed [3:0] sys_sh [8];
   logic signed [3:0] enc_sh [8];

   logic              accept, tail_step, step_en;
   logic              u, a, p;
   logic [27:0]       sys_pack, enc_pack;

   // Trellis step: information bit in LOAD, terminating bit (forces a = 0) in TAIL.
   always_comb begin
      accept    = (state == S_LOAD) && in_valid_i;
      tail_step = (state == S_TAIL);
      step_en   = accept || tail_step;
      u         = tail_step ? (s1 ^ s2) : in_bit_i;
      a         = u ^ s1 ^ s2;
      p         = a ^ s2;
   end

   // Next-state logic: 5 accepted bits, 2 tail steps, wait for credit, issue.
   always_comb begin
      state_nxt = state;
      case (state)
         S_LOAD:  if (accept && (step == 3'd4)) state_nxt = S_TAIL;
         S_TAIL:  if (step == 3'd6)             state_nxt = S_WAIT;
         S_WAIT:  if (credit)                   state_nxt = S_ISSUE;
         S_ISSUE:                               state_nxt = S_LOAD;
         default:                               state_nxt = S_LOAD;
      endcase
   end

   // Flatten the shadow nibbles, step 0 in the most significant nibble.
   always_comb begin
      sys_pack = '0;
      enc_pack = '0;
      for (int k = 0; k < 7; k++) begin
         sys_pack[27 - 4*k -: 4] = sys_sh[k];
         enc_pack[27 - 4*k -: 4] = enc_sh[k];
      end
   end

   // State register and step counter; the counter restarts after each issue.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state <= S_LOAD;
         step  <= 3'd0;
      end else begin
         state <= state_nxt;
         if (state == S_ISSUE)
            step <= 3'd0;
         else if (step_en)
            step <= step + 3'd1;
      end
   end

   // Encoder memory and per-step shadow nibbles; reset discards a partial frame.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         for (int k = 0; k < 8; k++) begin
            sys_sh[k] <= '0;
            enc_sh[k] <= '0;
         end
      end else if (step_en) begin
         s2           <= s1;
         s1           <= a;
         sys_sh[step] <= llr_map(u);
         enc_sh[step] <= llr_map(p);
      end
   end

   // Issue credit: cleared by an issue (which wins over a finish pulse), set by finish.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         credit      <= 1'b1;
         proto_err_o <= 1'b0;
      end else begin
         if (state == S_ISSUE)
            credit <= 1'b0;
         else if (siso_done_i)
            credit <= 1'b1;
         if (siso_done_i && credit && (state != S_ISSUE))
            proto_err_o <= 1'b1;
      end
   end

   // Registered outputs, loaded from the next state so they line up with ISSUE.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         in_ready_o  <= 1'b1;
         read_en_o   <= 1'b0;
         sys_o       <= '0;
         enc_o       <= '0;
         frame_cnt_o <= '0;
      end else begin
         in_ready_o <= (state_nxt == S_LOAD);
         read_en_o  <= (state_nxt == S_ISSUE);
         if (state_nxt == S_ISSUE) begin
            sys_o       <= sys_pack;
            enc_o       <= enc_pack;
            frame_cnt_o <= frame_cnt_o + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_rsc_frame_encoder.sv
// tb_rsc_frame_encoder: directed frames with hand-computed LLR words for
// rsc_frame_encoder at LLR_MAG 7 and 3, credit pacing and reset cases.
module tb_rsc_frame_encoder;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_bit;
   logic        siso_done;
   logic        in_ready,  in_ready3;
   logic        read_en,   read_en3;
   logic [27:0] sys,       sys3;
   logic [27:0] enc,       enc3;
   logic [15:0] frame_cnt, frame_cnt3;
   logic        proto_err, proto_err3;

   int checks = 0;
   int errors = 0;
   int lat;

   rsc_frame_encoder #(.LLR_MAG(7)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .in_valid_i(in_valid), .in_bit_i(in_bit),
      .in_ready_o(in_ready), .siso_done_i(siso_done), .read_en_o(read_en),
      .sys_o(sys), .enc_o(enc), .frame_cnt_o(frame_cnt), .proto_err_o(proto_err)
   );

   rsc_frame_encoder #(.LLR_MAG(3)) dut3 (
      .clk_i(clk), .reset_n_i(reset_n), .in_valid_i(in_valid), .in_bit_i(in_bit),
      .in_ready_o(in_ready3), .siso_done_i(siso_done), .read_en_o(read_en3),
      .sys_o(sys3), .enc_o(enc3), .frame_cnt_o(frame_cnt3), .proto_err_o(proto_err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout obs=running exp=finished");
      $fatal(1, "simulation timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // bits[4] is the first information bit; gap bubbles are inserted after bit 2.
   task automatic send_frame(input logic [4:0] bits, input int gap);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_bit   = bits[4 - i];
         check("in_ready_load", {31'd0, in_ready}, 32'd1);
         tick();
         if (i == 2 && gap > 0) begin
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) tick();
         end
      end
      in_valid = 1'b0;
      in_bit   = 1'b0;
   endtask

   // Returns the number of cycles until read_en is seen; fails if never seen.
   task automatic wait_issue(input int budget, output int latency);
      latency = -1;
      for (int k = 0; k < budget; k++) begin
         if (read_en) begin
            latency = k;
            break;
         end
         tick();
      end
      check("issue_seen", {31'd0, read_en}, 32'd1);
   endtask

   initial begin
      reset_n   = 1'b1;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      siso_done = 1'b0;
      #2;

      // Reset values
      do_reset();
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_read_en",   {31'd0, read_en},   32'd0);
      check("rst_sys",       {4'd0, sys},        32'd0);
      check("rst_enc",       {4'd0, enc},        32'd0);
      check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      check("rst_proto_err", {31'd0, proto_err}, 32'd0);

      // All-zero frame, credit granted by reset
      send_frame(5'b00000, 0);
      wait_issue(20, lat);
      check("zero_latency", lat, 32'd3);
      check("zero_sys", {4'd0, sys}, 32'h09999999);
      check("zero_enc", {4'd0, enc}, 32'h09999999);
      check("zero_cnt", {16'd0, frame_cnt}, 32'd1);
      tick();
      check("post_issue_read_en",  {31'd0, read_en},  32'd0);
      check("post_issue_in_ready", {31'd0, in_ready}, 32'd1);

      // 1,0,0,0,0 at both magnitudes, with bubbles in the middle
      do_reset();
      send_frame(5'b10000, 2);
      wait_issue(20, lat);
      check("one_latency", lat, 32'd3);
      check("one_sys",  {4'd0, sys},  32'h07999997);
      check("one_enc",  {4'd0, enc},  32'h07779777);
      check("mag3_sys", {4'd0, sys3}, 32'h03DDDDD3);
      check("mag3_enc", {4'd0, enc3}, 32'h0333D333);
      check("one_final_state", {30'd0, dut.s1, dut.s2}, 32'd0);

      // Second frame without finish stalls in WAIT
      tick();
      send_frame(5'b10000, 0);
      for (int k = 0; k < 6; k++) tick();
      check("stall_read_en",  {31'd0, read_en},  32'd0);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_cnt", {16'd0, frame_cnt}, 32'd1);
      siso_done = 1'b1;
      tick();
      siso_done = 1'b0;
      check("done_plus1_read_en", {31'd0, read_en}, 32'd0);
      tick();
      check("done_plus2_read_en", {31'd0, read_en}, 32'd1);
      check("done_cnt", {16'd0, frame_cnt}, 32'd2);
      check("done_sys", {4'd0, sys}, 32'h07999997);
      check("done_proto_err", {31'd0, proto_err}, 32'd0);
      tick();

      // Finish while credit is 0 grants credit; finish in ISSUE is ignored
      siso_done = 1'b1;
      tick();
      siso_done = 1'b0;
      check("grant_credit", {31'd0, dut.credit}, 32'd1);
      check("grant_no_err", {31'd0, proto_err}, 32'd0);
      send_frame(5'b00000, 0);
      wait_issue(20, lat);
      check("third_latency", lat, 32'd3);
      siso_done = 1'b1;
      tick();
      siso_done = 1'b0;
      check("issue_done_credit", {31'd0, dut.credit}, 32'd0);
      check("issue_done_no_err", {31'd0, proto_err}, 32'd0);
      check("third_cnt", {16'd0, frame_cnt}, 32'd3);

      // Double finish raises a sticky protocol error
      siso_done = 1'b1;
      tick();
      siso_done = 1'b0;
      check("first_done_no_err", {31'd0, proto_err}, 32'd0);
      siso_done = 1'b1;
      tick();
      siso_done = 1'b0;
      check("double_done_err", {31'd0, proto_err}, 32'd1);
      for (int k = 0; k < 3; k++) tick();
      check("err_sticky", {31'd0, proto_err}, 32'd1);

      // Reset mid-frame discards partial data
      do_reset();
      in_valid = 1'b1;
      in_bit   = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      in_valid = 1'b0;
      do_reset();
      check("midrst_cnt", {16'd0, frame_cnt}, 32'd0);
      check("midrst_err", {31'd0, proto_err}, 32'd0);
      check("midrst_state", {29'd0, dut.step, 1'b0}, 32'd0);
      send_frame(5'b00000, 0);
      wait_issue(20, lat);
      check("midrst_sys", {4'd0, sys}, 32'h09999999);
      check("midrst_enc", {4'd0, enc}, 32'h09999999);
      check("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rsc_frame_encoder.md
# rsc_frame_encoder

Transmit-side source for the SISO decoder. It accepts a serial stream of information bits and encodes them with a rate-1/2 recursive systematic convolutional (RSC) code (feedback 7, feedforward 5 octal, trellis-terminated). Each 7-step frame is mapped to signed 4-bit LLR nibbles and delivered to the SISO as one `sys`/`enc` word pair per read-enable pulse. Frame issue is paced by the SISO `finish` pulse.

## Interface
- `LLR_MAG`, default 7: magnitude of the emitted LLR, legal range 1..7. Bit 1 maps to +`LLR_MAG`, bit 0 maps to −`LLR_MAG` (4-bit two's complement).
- `clk_i` in 1: single clock; all state changes on the rising edge.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `in_valid_i` in 1: information bit on `in_bit_i` is valid.
- `in_bit_i` in 1: information bit.
- `in_ready_o` out 1: block accepts a bit this cycle; a transfer occurs when `in_valid_i` and `in_ready_o` are both high.
- `siso_done_i` in 1: SISO `finish` pulse, one cycle per decoded frame; grants one issue credit.
- `read_en_o` out 1: one-cycle pulse to the SISO `read_en_i`; `sys_o`/`enc_o` are valid in the same cycle.
- `sys_o` out 28: systematic LLRs; step 0 in [27:24], step 6 in [3:0].
- `enc_o` out 28: parity LLRs; same nibble order as `sys_o`.
- `frame_cnt_o` out 16: count of frames issued; wraps from 0xFFFF to 0.
- `proto_err_o` out 1: sticky; set when `siso_done_i` arrives while a credit is already held and no issue occurs that cycle.

## Operation
- Encoder state is `s1` (newest) and `s2`.
  - Per step with input `u`: `a = u^s1^s2`, `p = a^s2`; then `s2 <= s1`, `s1 <= a`.
  - The systematic bit is `u` and the parity bit is `p`.
- Each frame is 5 information steps followed by 2 tail steps. A tail step uses `u = s1^s2`, which forces `a = 0`, so the state ends at 00 after every frame.
- Each step writes its sys and parity nibbles into shadow registers at the step index (0..6). The step counter is 3 bits and resets to 0 at each frame start.
- FSM:
  - LOAD: `in_ready_o = 1`. Each accepted bit runs one step. After the 5th accepted bit, go to TAIL.
  - TAIL: 2 cycles, one tail step per cycle, `in_ready_o = 0`. Then go to WAIT.
  - WAIT: `in_ready_o = 0`. If `credit = 1`, go to ISSUE.
  - ISSUE: one cycle. `read_en_o = 1`; `sys_o`/`enc_o` load from the shadow registers; `credit` clears; `frame_cnt_o` increments. Then go to LOAD.
- Credit:
  - Set to 1 at reset, so the first frame needs no `finish`.
  - Cleared in the ISSUE cycle. This has priority: a `siso_done_i` in the ISSUE cycle is ignored and does not raise `proto_err_o`.
  - Otherwise set when `siso_done_i = 1`.
- `sys_o`/`enc_o` hold their value between issues. `read_en_o` is low outside ISSUE.
- Bubbles: if `in_valid_i` is low in LOAD, no step is taken and the state holds.
- Reset mid-frame (asserted in any state): discards the partial frame and shadow registers; encoder state returns to 00.

## Timing
- Reset values:
  - `in_ready_o = 1`, `read_en_o = 0`, `sys_o = enc_o = 0`, `frame_cnt_o = 0`, `proto_err_o = 0`.
  - FSM = LOAD, step = 0, credit = 1.
- Minimum frame period is 9 cycles: 5 LOAD + 2 TAIL + 1 WAIT + 1 ISSUE.
- With credit held, `read_en_o` rises exactly 4 cycles after the cycle in which the 5th bit is accepted.
- Without credit, `read_en_o` rises 2 cycles after the `siso_done_i` pulse, provided the FSM is already in WAIT.
- The first bit of the next frame can be accepted in the cycle after ISSUE.
- All outputs are registered; there is no combinational path from an input to an output.

## Test plan
- Reset, then bits 0,0,0,0,0 → one `read_en_o` pulse with `sys_o = 28'h9999999`, `enc_o = 28'h9999999`, `frame_cnt_o = 1`.
- Reset, then bits 1,0,0,0,0 → `sys_o = 28'h7999997`, `enc_o = 28'h7779777`. The tail inputs are 0,1 and the final encoder state is 00.
- `LLR_MAG = 3`, bits 1,0,0,0,0 → `sys_o = 28'h3DDDDD3`, `enc_o = 28'h333D333`.
- Two back-to-back frames with no `siso_done_i` → the second frame stalls in WAIT with `in_ready_o = 0`. A `siso_done_i` pulse → `read_en_o` 2 cycles later and `frame_cnt_o = 2`.
- `siso_done_i` pulsed while credit is already 1 → `proto_err_o = 1` and it stays set. `siso_done_i` in the ISSUE cycle → no error and credit = 0.
- `reset_n_i` dropped after 3 bits, then released, then bits 0,0,0,0,0 → no stale data; `sys_o = 28'h9999999`, `frame_cnt_o = 1`.
